// File: rtl/mux2x1_feeder.sv
`default_nettype none
// ============================================================================
// Module   : mux2x1_feeder
// Brief    : Buffers 2-bit words (2-deep FIFO) and serialises each one onto a
//            downstream 2:1 mux by stepping sel 0 -> 1, HOLD cycles per bit.
//            Optional word counter output enabled by MUX_FEED_WCNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mux2x1_feeder #(
    parameter int unsigned HOLD = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  in_data,
    output logic        in_ready,
    output logic [1:0]  din,
    output logic        sel,
    output logic        phase_valid,
    output logic        busy,
    output logic        word_done
`ifdef MUX_FEED_WCNT_EN
    ,
    output logic [15:0] wcnt
`endif
);

    // HOLD of 0 is treated as 1
    localparam logic [7:0] HOLD_M1 = (HOLD <= 1) ? 8'd0 : 8'(HOLD - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BIT0 = 2'd1;
    localparam logic [1:0] S_BIT1 = 2'd2;

    logic [1:0] state;
    logic [7:0] hcnt;
    logic [1:0] fifo_mem [2];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;
    logic       word_end;

    assign in_ready = !rst && (count < 2'd2);
    assign push     = in_valid && in_ready;
    assign word_end = (state == S_BIT1) && (hcnt == 8'd0);
    assign pop      = (count != 2'd0) && ((state == S_IDLE) || word_end);
    assign busy     = (state != S_IDLE) || (count != 2'd0);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // word_done is registered one cycle ahead so it lands on the final BIT1 cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            hcnt        <= 8'd0;
            din         <= 2'b00;
            sel         <= 1'b0;
            phase_valid <= 1'b0;
            word_done   <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        din         <= fifo_mem[rd_ptr];
                        sel         <= 1'b0;
                        phase_valid <= 1'b1;
                        hcnt        <= HOLD_M1;
                        state       <= S_BIT0;
                    end
                end
                S_BIT0: begin
                    if (hcnt == 8'd0) begin
                        sel       <= 1'b1;
                        hcnt      <= HOLD_M1;
                        state     <= S_BIT1;
                        word_done <= (HOLD_M1 == 8'd0);
                    end else begin
                        hcnt <= hcnt - 8'd1;
                    end
                end
                S_BIT1: begin
                    if (hcnt == 8'd0) begin
                        if (pop) begin
                            din         <= fifo_mem[rd_ptr];
                            sel         <= 1'b0;
                            phase_valid <= 1'b1;
                            hcnt        <= HOLD_M1;
                            state       <= S_BIT0;
                        end else begin
                            sel         <= 1'b0;
                            phase_valid <= 1'b0;
                            state       <= S_IDLE;
                        end
                    end else begin
                        hcnt      <= hcnt - 8'd1;
                        word_done <= (hcnt == 8'd1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef MUX_FEED_WCNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt <= 16'd0;
        end else if (word_done) begin
            wcnt <= wcnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire
